// File: rtl/serializer_tx.sv
// serializer_tx: parallel-to-serial transmitter for the SAP-3 bit-serial link.
// Accepts a WIDTH-bit word over valid/ready, emits a one-cycle start strobe,
// then the word LSB-first on serial_out, one bit per clock.
// Optional build macro SERIALIZER_TX_SKID_EN adds a one-entry holding buffer
// so that a word accepted while a frame is in flight follows with no gap.
module serializer_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             start,
    output logic             serial_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             hs;
    logic             last_bit;

`ifdef SERIALIZER_TX_SKID_EN
    logic [WIDTH-1:0] buf_data, buf_data_n;
    logic             buf_valid, buf_valid_n;

    // The buffer is the only thing that can refuse a word.
    assign in_ready = !buf_valid;
`else
    // Without a buffer a word can only be taken while nothing is in flight.
    assign in_ready = (state == IDLE);
`endif

    assign hs       = in_valid & in_ready;
    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

    // Next-state, shift-register, counter and buffer update.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
`ifdef SERIALIZER_TX_SKID_EN
        buf_data_n  = buf_data;
        buf_valid_n = buf_valid;
`endif
        case (state)
            IDLE: begin
                if (hs) begin
                    shreg_n = in_data;
                    state_n = START;
                end
            end
            START: begin
                state_n = SHIFT;
                cnt_n   = '0;
`ifdef SERIALIZER_TX_SKID_EN
                if (hs) begin
                    buf_data_n  = in_data;
                    buf_valid_n = 1'b1;
                end
`endif
            end
            SHIFT: begin
                if (cnt != CNT_LAST) begin
                    cnt_n   = cnt + CW'(1);
                    shreg_n = shreg >> 1;
`ifdef SERIALIZER_TX_SKID_EN
                    if (hs) begin
                        buf_data_n  = in_data;
                        buf_valid_n = 1'b1;
                    end
`endif
                end else begin
`ifdef SERIALIZER_TX_SKID_EN
                    // Last bit: chain straight into the next frame if a word
                    // is waiting in the buffer or arrives right now.
                    if (buf_valid) begin
                        shreg_n     = buf_data;
                        buf_valid_n = 1'b0;
                        state_n     = START;
                    end else if (hs) begin
                        shreg_n = in_data;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n = IDLE;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State registers; outputs are registered from the next-state values so
    // they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            start      <= 1'b0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            start      <= (state_n == START);
            serial_out <= (state_n == SHIFT) ? shreg_n[0] : 1'b0;
            busy       <= (state_n != IDLE);
            frame_done <= last_bit;
        end
    end

`ifdef SERIALIZER_TX_SKID_EN
    // Holding buffer; a reset drops any pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data  <= '0;
            buf_valid <= 1'b0;
        end else begin
            buf_data  <= buf_data_n;
            buf_valid <= buf_valid_n;
        end
    end
`endif

endmodule
